shift_tx: RTL and testbench

SHIFT_TX -- requirements
Module: shift_tx

---
 rtl/shift_tx.sv | 117 +++++++++++
 tb/tb_shift_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift_tx.sv
// Serial transmitter: frames a WIDTH-bit word as start(0), data MSB first, stop(1),
// holding each bit for DIV clock cycles; ready/load handshake, one-cycle done pulse.
module shift_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             q,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic             tick;

  // tick marks the last cycle of the current bit period
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (load) begin
          state_d = START;
          shift_d = d;
          bit_d   = BIT_TOP;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          div_d   = '0;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          div_d   = '0;
          shift_d = shift_q << 1;
          if (bit_q == '0) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          div_d   = '0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q = 1'b1;
    unique case (state_q)
      START:   q = 1'b0;
      DATA:    q = shift_q[WIDTH-1];
      default: q = 1'b1;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: two instances (8-bit/DIV=4 and 4-bit/DIV=1) checked against
// a frame model that derives the expected line level from the cycle index.
module tb_shift_tx;

  logic       clk = 1'b0;
  logic       rn;
  logic [7:0] da;
  logic       la;
  logic       rdy_a, q_a, busy_a, done_a;
  logic [3:0] db;
  logic       lb;
  logic       rdy_b, q_b, busy_b, done_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  shift_tx #(.WIDTH(8), .DIV(4)) u_a (
    .clk(clk), .r(rn), .d(da), .load(la),
    .ready(rdy_a), .q(q_a), .busy(busy_a), .done(done_a)
  );

  shift_tx #(.WIDTH(4), .DIV(1)) u_b (
    .clk(clk), .r(rn), .d(db), .load(lb),
    .ready(rdy_b), .q(q_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level k cycles after acceptance: bit index k/dv within start,data,stop
  function automatic logic model_bit(input logic [31:0] word, input int w, input int dv, input int k);
    int idx;
    idx = k / dv;
    if (idx == 0) return 1'b0;
    if (idx <= w) return word[w-idx];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit sel, input logic [31:0] word);
    check(sel ? "b_ready_pre" : "a_ready_pre", sel ? rdy_b : rdy_a, 1);
    if (sel) begin db = word[3:0]; lb = 1'b1; end
    else     begin da = word[7:0]; la = 1'b1; end
    step();
    if (sel) lb = 1'b0;
    else     la = 1'b0;
  endtask

  // Entered on the first cycle after acceptance; returns in the done cycle.
  // mode 1: scramble d every cycle; mode 2: competing load of FF at cycle 10.
  task automatic run_frame(input bit sel, input logic [31:0] word, input int mode);
    int w, dv, len;
    w   = sel ? 4 : 8;
    dv  = sel ? 1 : 4;
    len = (w + 2) * dv;
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s_q[%0d]", sel ? "b" : "a", k), sel ? q_b : q_a, model_bit(word, w, dv, k));
      check("busy_in_frame", sel ? busy_b : busy_a, 1);
      check("ready_in_frame", sel ? rdy_b : rdy_a, 0);
      check("done_in_frame", sel ? done_b : done_a, 0);
      if (mode == 1) begin
        if (sel) db = 4'($urandom);
        else     da = 8'($urandom);
      end
      if (mode == 2 && k == 10) begin da = 8'hFF; la = 1'b1; end
      if (mode == 2 && k == 11) la = 1'b0;
      step();
    end
    check("done_pulse", sel ? done_b : done_a, 1);
    check("busy_after", sel ? busy_b : busy_a, 0);
    check("ready_after", sel ? rdy_b : rdy_a, 1);
    check("q_idle_after", sel ? q_b : q_a, 1);
  endtask

  initial begin
    logic [7:0] w8;
    logic [5:0] exp34;
    rn = 1'b0; da = '0; la = 1'b0; db = '0; lb = 1'b0;
    repeat (3) step();
    check("rst_q", q_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_ready", rdy_a, 1);
    check("rst_done", done_a, 0);
    rn = 1'b1;
    step();

    // basic A5 frame
    accept(0, 32'hA5);
    run_frame(0, 32'hA5, 0);
    step();
    check("done_one_cycle", done_a, 0);

    // back-to-back FF then 00 with load held
    da = 8'hFF; la = 1'b1;
    step();
    run_frame(0, 32'hFF, 0);
    da = 8'h00;
    step();
    la = 1'b0;
    run_frame(0, 32'h00, 0);
    step();

    // load while busy is ignored
    accept(0, 32'h3C);
    run_frame(0, 32'h3C, 2);
    step();
    check("no_queued_frame", busy_a, 0);

    // reset mid-frame
    w8 = 8'($urandom);
    accept(0, {24'h0, w8});
    for (int k = 0; k < 17; k++) begin
      check($sformatf("pre_rst_q[%0d]", k), q_a, model_bit({24'h0, w8}, 8, 4, k));
      step();
    end
    #2 rn = 1'b0;
    #1;
    check("midrst_q", q_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_ready", rdy_a, 1);
    check("midrst_done", done_a, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_done_after_rst", done_a, 0);
    end
    w8 = 8'($urandom);
    rn = 1'b1; da = w8; la = 1'b1;
    step();
    la = 1'b0;
    run_frame(0, {24'h0, w8}, 0);
    step();

    // DIV=1, WIDTH=4, 1001
    accept(1, 32'h9);
    exp34 = 6'b010011;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("div1_q[%0d]", k), q_b, exp34[5-k]);
      step();
    end
    check("div1_done", done_b, 1);
    step();

    // d scrambled while busy, random words on both instances
    for (int i = 0; i < 4; i++) begin
      w8 = 8'($urandom);
      accept(0, {24'h0, w8});
      run_frame(0, {24'h0, w8}, 1);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 6; i++) begin
      w8 = 8'($urandom);
      accept(1, {28'h0, w8[3:0]});
      run_frame(1, {28'h0, w8[3:0]}, i % 2);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
